// File: rtl/light_package.sv
// Shared types for the traffic light controller and its sensor front end.
package light_package;

  typedef enum logic [1:0] {
    red,
    yellow,
    green
  } colors;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESENT,
    GAP
  } lane_state_t;

  localparam int NUM_LANES = 5;

endpackage

// File: rtl/tlc_sensor_lane.sv
// One detector lane: 2-flop synchronizer, debounce/gap FSM, optional request latch.
// Define SENSOR_REQ_LATCH_EN to hold a debounced request until the lane's light shows green.
module tlc_sensor_lane
  import light_package::*;
#(
  parameter int DEBOUNCE   = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  raw,
  input  colors light,
  output logic  sensor
);

  localparam int CNT_MAX = (DEBOUNCE > GAP_CYCLES) ? DEBOUNCE : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic          sync_meta;
  logic          raw_sync;
  lane_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          det;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      raw_sync  <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
    end else begin
      sync_meta <= raw;
      raw_sync  <= sync_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  // NOTE: defaults first so no path through this block leaves a target unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (raw_sync) begin
          if (DEBOUNCE == 1) begin
            state_d = PRESENT;
          end else begin
            state_d = ARMING;
            cnt_d   = CW'(1);
          end
        end
      end
      ARMING: begin
        if (!raw_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESENT: begin
        if (!raw_sync) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = GAP;
            cnt_d   = CW'(1);
          end
        end
      end
      GAP: begin
        if (raw_sync) begin
          state_d = PRESENT;
        end else if (cnt_q == CW'(GAP_CYCLES)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign det = (state_q == PRESENT) || (state_q == GAP);

`ifdef SENSOR_REQ_LATCH_EN
  logic req_q;
  logic req_set;

  // A fresh debounce wins over a simultaneous green so the new car is not lost.
  assign req_set = (state_d == PRESENT) && ((state_q == IDLE) || (state_q == ARMING));

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= 1'b0;
    end else if (req_set) begin
      req_q <= 1'b1;
    end else if (light == green) begin
      req_q <= 1'b0;
    end
  end

  assign sensor = det | req_q;
`else
  logic unused_light;
  assign unused_light = ^light;
  assign sensor       = det;
`endif

endmodule

// File: rtl/tlc_sensor_conditioner.sv
// Conditions the five raw loop detectors into request inputs for traffic_light_controller.
// Define SENSOR_REQ_LATCH_EN to latch each request until its light has shown green.
module tlc_sensor_conditioner
  import light_package::*;
#(
  parameter int DEBOUNCE   = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  e_str_raw,
  input  logic  w_str_raw,
  input  logic  e_left_raw,
  input  logic  w_left_raw,
  input  logic  ns_raw,
  input  colors e_str_light,
  input  colors w_str_light,
  input  colors e_left_light,
  input  colors w_left_light,
  input  colors ns_light,
  output logic  e_str_sensor,
  output logic  w_str_sensor,
  output logic  e_left_sensor,
  output logic  w_left_sensor,
  output logic  ns_sensor
);

  logic [NUM_LANES-1:0] raw_vec;
  logic [NUM_LANES-1:0] sensor_vec;
  colors                light_vec [NUM_LANES];

  // Lane order: 4=e_str, 3=w_str, 2=e_left, 1=w_left, 0=ns.
  assign raw_vec = {e_str_raw, w_str_raw, e_left_raw, w_left_raw, ns_raw};

  assign light_vec[4] = e_str_light;
  assign light_vec[3] = w_str_light;
  assign light_vec[2] = e_left_light;
  assign light_vec[1] = w_left_light;
  assign light_vec[0] = ns_light;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tlc_sensor_lane #(
      .DEBOUNCE  (DEBOUNCE),
      .GAP_CYCLES(GAP_CYCLES)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .light (light_vec[i]),
      .sensor(sensor_vec[i])
    );
  end

  assign {e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor} = sensor_vec;

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// Directed bench for tlc_sensor_conditioner with DEBOUNCE=3, GAP_CYCLES=4.
// Expectations follow SENSOR_REQ_LATCH_EN when it is defined for the build.
module tb_tlc_sensor_conditioner;
  import light_package::*;

`ifdef SENSOR_REQ_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] raw_v = '0;
  colors      e_str_light = red, w_str_light = red, e_left_light = red;
  colors      w_left_light = red, ns_light = red;
  logic       e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
  logic [4:0] sens;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] raw;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [18];

  always #5 clk = ~clk;

  tlc_sensor_conditioner #(
    .DEBOUNCE  (3),
    .GAP_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .e_str_raw    (raw_v[4]),
    .w_str_raw    (raw_v[3]),
    .e_left_raw   (raw_v[2]),
    .w_left_raw   (raw_v[1]),
    .ns_raw       (raw_v[0]),
    .e_str_light  (e_str_light),
    .w_str_light  (w_str_light),
    .e_left_light (e_left_light),
    .w_left_light (w_left_light),
    .ns_light     (ns_light),
    .e_str_sensor (e_str_sensor),
    .w_str_sensor (w_str_sensor),
    .e_left_sensor(e_left_sensor),
    .w_left_sensor(w_left_sensor),
    .ns_sensor    (ns_sensor)
  );

  assign sens = {e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor};

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    raw_v        = '0;
    e_str_light  = red;
    w_str_light  = red;
    e_left_light = red;
    w_left_light = red;
    ns_light     = red;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] exp_v;

    // Row i drives cycle i; its expectation is the sensor vector at cycle i+1.
    for (int i = 0; i < 18; i++) begin
      tbl[i].raw = 5'b10000;
      tbl[i].exp = (i >= 4) ? 5'b10000 : 5'b00000;
    end
    tbl[8].raw = 5'b10001;
    tbl[9].raw = 5'b10001;

    do_reset();
    check("reset_state", sens, 5'b00000);

    // e_str debounce to cycle 5, then a 2-cycle ns glitch that must be rejected.
    for (int i = 0; i < 18; i++) begin
      raw_v = tbl[i].raw;
      step();
      check($sformatf("table_row%0d", i), sens, tbl[i].exp);
    end

    // w_left: 3-cycle dropout bridged, then a long dropout that falls at f+7.
    do_reset();
    raw_v = 5'b00010;
    repeat (6) step();
    check("wl_present", sens, 5'b00010);
    raw_v = 5'b00000;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("wl_short_gap_lo%0d", k), sens, 5'b00010);
    end
    raw_v = 5'b00010;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("wl_short_gap_hi%0d", k), sens, 5'b00010);
    end
    raw_v = 5'b00000;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("wl_long_gap_f+%0d", k), sens, (k < 7) ? 5'b00010 : 5'b00000);
    end

    // e_left and ns both high cycles 0..4; ns_light green through cycle 4 (set vs clear).
    do_reset();
    raw_v    = 5'b00101;
    ns_light = green;
    for (int c = 1; c <= 25; c++) begin
      step();
      exp_v = '0;
      if (c >= 5 && c <= 11)      exp_v[2] = 1'b1;
      else if (c >= 12 && c <= 20) exp_v[2] = LATCH;
      if (c >= 5 && c <= 11)      exp_v[0] = 1'b1;
      else if (c >= 12 && c <= 22) exp_v[0] = LATCH;
      check($sformatf("latch_c%0d", c), sens, exp_v);
      if (c == 5) begin
        raw_v    = 5'b00000;
        ns_light = red;
      end
      if (c == 20) e_left_light = green;
      if (c == 22) ns_light = green;
    end

    // w_str: reset while in GAP, then a fresh debounce from IDLE.
    do_reset();
    raw_v = 5'b01000;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 7) raw_v = 5'b00000;
    end
    check("ws_mid_gap", sens, 5'b01000);
    reset = 1'b1;
    step();
    check("ws_reset_mid_gap", sens, 5'b00000);
    reset = 1'b0;
    raw_v = 5'b01000;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("ws_redebounce_r+%0d", k), sens, (k >= 5) ? 5'b01000 : 5'b00000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
